tt_nco: RTL

- Numerically controlled oscillator that closes the DPLL loop.
- Consumes the signed 16-bit filtered control word from the loop filter (tt_lpf) and produces the PLL output clock, which drives the PFD, filter, feedback divider and lock flop.
- Runs on a fast free-running system clock. It maps control to a clamped frequency control word (FCW), then accumulates phase; the accumulator MSB is the output clock.
- Participates in the design scan chain.

---
 rtl/tt_dpll_pkg.sv | 16 +
 rtl/tt_nco_if.sv | 37 +++
 rtl/tt_nco_fcw_map.sv | 51 +++++
 rtl/tt_nco.sv | 102 ++++++++++
 4 files changed

// File: rtl/tt_dpll_pkg.sv
// Shared DPLL definitions: NCO widths, centre FCW, clamp limits and the
// control-word / FCW typedefs used by the loop filter and the NCO.
package tt_dpll_pkg;

  localparam int CTRL_W     = 16;
  localparam int ACC_W      = 24;
  localparam int GAIN_SHIFT = 4;

  localparam logic [ACC_W-1:0] BASE_FCW = 24'h19999A;
  localparam logic [ACC_W-1:0] FCW_MIN  = 24'h000001;
  localparam logic [ACC_W-1:0] FCW_MAX  = 24'h7FFFFF;

  typedef logic signed [CTRL_W-1:0] ctrl_t;
  typedef logic        [ACC_W-1:0]  fcw_t;

endpackage : tt_dpll_pkg

// File: rtl/tt_nco_if.sv
// Functional bundle between the loop filter and the NCO.
//   i_control : signed control word into the NCO
//   i_enable  : oscillator run enable
//   o_clk     : NCO output clock (accumulator MSB)
//   o_wrap    : one-cycle accumulator carry pulse
//   o_sat_hi  : FCW clamped at its upper limit
//   o_sat_lo  : FCW clamped at its lower limit
// master = control source (loop filter / bench), slave = the NCO.
interface tt_nco_if;
  import tt_dpll_pkg::*;

  ctrl_t i_control;
  logic  i_enable;
  logic  o_clk;
  logic  o_wrap;
  logic  o_sat_hi;
  logic  o_sat_lo;

  modport master (
    output i_control,
    output i_enable,
    input  o_clk,
    input  o_wrap,
    input  o_sat_hi,
    input  o_sat_lo
  );

  modport slave (
    input  i_control,
    input  i_enable,
    output o_clk,
    output o_wrap,
    output o_sat_hi,
    output o_sat_lo
  );

endinterface : tt_nco_if

// File: rtl/tt_nco_fcw_map.sv
// Combinational control-to-FCW mapping: FCW = BASE + control * 2^GAIN_SHIFT,
// clamped to [MIN, MAX].
//   i_ctrl   : registered signed control word
//   o_fcw    : clamped frequency control word
//   o_sat_hi : sum exceeded MAX
//   o_sat_lo : sum fell below MIN (including negative sums)
module tt_nco_fcw_map
  import tt_dpll_pkg::*;
#(
  parameter int   GAIN_SHIFT_P = GAIN_SHIFT,
  parameter fcw_t BASE_P       = BASE_FCW,
  parameter fcw_t MIN_P        = FCW_MIN,
  parameter fcw_t MAX_P        = FCW_MAX
) (
  input  ctrl_t i_ctrl,
  output fcw_t  o_fcw,
  output logic  o_sat_hi,
  output logic  o_sat_lo
);

  // Wide enough that the shifted control plus base can never overflow.
  localparam int SUM_W = ACC_W + CTRL_W + GAIN_SHIFT_P;

  logic signed [SUM_W-1:0] ctrl_ext_s;
  logic signed [SUM_W-1:0] base_ext_s;
  logic signed [SUM_W-1:0] min_ext_s;
  logic signed [SUM_W-1:0] max_ext_s;
  logic signed [SUM_W-1:0] sum_s;

  // Signed add of base and scaled control, then clamp to the legal FCW range.
  always_comb begin
    ctrl_ext_s = {{(SUM_W-CTRL_W){i_ctrl[CTRL_W-1]}}, i_ctrl};
    base_ext_s = {{(SUM_W-ACC_W){1'b0}}, BASE_P};
    min_ext_s  = {{(SUM_W-ACC_W){1'b0}}, MIN_P};
    max_ext_s  = {{(SUM_W-ACC_W){1'b0}}, MAX_P};
    sum_s      = base_ext_s + (ctrl_ext_s <<< GAIN_SHIFT_P);
    o_fcw      = sum_s[ACC_W-1:0];
    o_sat_hi   = 1'b0;
    o_sat_lo   = 1'b0;
    if (sum_s > max_ext_s) begin
      o_fcw    = MAX_P;
      o_sat_hi = 1'b1;
    end else if (sum_s < min_ext_s) begin
      o_fcw    = MIN_P;
      o_sat_lo = 1'b1;
    end else begin
      o_fcw    = sum_s[ACC_W-1:0];
    end
  end

endmodule : tt_nco_fcw_map

// File: rtl/tt_nco.sv
// Numerically controlled oscillator closing the DPLL loop.
// Pipeline: control register -> clamped FCW register -> phase accumulator.
// The accumulator MSB is the output clock. ctrl_q and acc_q form a 40-bit
// scan chain (scan_in -> ctrl_q[0..15] -> acc_q[0..23] -> scan_out).
//   i_clk, i_rst_n        : system clock, async active-low reset
//   nco_if (slave)        : control/enable in, clock/wrap/saturation out
//   i_scan_en, i_scan_in  : scan shift enable and data in
//   o_scan_out            : scan data out (acc MSB)
module tt_nco
  import tt_dpll_pkg::*;
#(
  parameter int   GAIN_SHIFT_P = GAIN_SHIFT,
  parameter fcw_t BASE_P       = BASE_FCW,
  parameter fcw_t MIN_P        = FCW_MIN,
  parameter fcw_t MAX_P        = FCW_MAX
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  tt_nco_if.slave      nco_if,
  input  logic         i_scan_en,
  input  logic         i_scan_in,
  output logic         o_scan_out
);

  ctrl_t ctrl_q,   ctrl_d;
  fcw_t  fcw_q,    fcw_d;
  logic  sat_hi_q, sat_hi_d;
  logic  sat_lo_q, sat_lo_d;
  fcw_t  acc_q,    acc_d;
  logic  wrap_q,   wrap_d;

  fcw_t         map_fcw_s;
  logic         map_sat_hi_s;
  logic         map_sat_lo_s;
  logic [ACC_W:0] acc_sum_s;

  tt_nco_fcw_map #(
    .GAIN_SHIFT_P (GAIN_SHIFT_P),
    .BASE_P       (BASE_P),
    .MIN_P        (MIN_P),
    .MAX_P        (MAX_P)
  ) u_fcw_map (
    .i_ctrl   (ctrl_q),
    .o_fcw    (map_fcw_s),
    .o_sat_hi (map_sat_hi_s),
    .o_sat_lo (map_sat_lo_s)
  );

  // Next-state: scan shift has priority, otherwise the three functional stages.
  always_comb begin
    ctrl_d    = ctrl_q;
    fcw_d     = fcw_q;
    sat_hi_d  = sat_hi_q;
    sat_lo_d  = sat_lo_q;
    acc_d     = acc_q;
    wrap_d    = wrap_q;
    acc_sum_s = {1'b0, acc_q} + {1'b0, fcw_q};
    if (i_scan_en) begin
      ctrl_d = {ctrl_q[CTRL_W-2:0], i_scan_in};
      acc_d  = {acc_q[ACC_W-2:0], ctrl_q[CTRL_W-1]};
    end else begin
      ctrl_d   = nco_if.i_control;
      fcw_d    = map_fcw_s;
      sat_hi_d = map_sat_hi_s;
      sat_lo_d = map_sat_lo_s;
      if (nco_if.i_enable) begin
        acc_d  = acc_sum_s[ACC_W-1:0];
        wrap_d = acc_sum_s[ACC_W];
      end else begin
        // Disabled oscillator parks at phase 0 so restart is deterministic.
        acc_d  = {ACC_W{1'b0}};
        wrap_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q   <= '0;
      fcw_q    <= BASE_P;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
      acc_q    <= {ACC_W{1'b0}};
      wrap_q   <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      fcw_q    <= fcw_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
      acc_q    <= acc_d;
      wrap_q   <= wrap_d;
    end
  end

  assign nco_if.o_clk    = acc_q[ACC_W-1];
  assign nco_if.o_wrap   = wrap_q;
  assign nco_if.o_sat_hi = sat_hi_q;
  assign nco_if.o_sat_lo = sat_lo_q;
  assign o_scan_out      = acc_q[ACC_W-1];

endmodule : tt_nco
